packet_averager: RTL and testbench

Receives a byte stream from the serial front end, frames it into packets (one header byte followed by four data bytes), computes the truncated mean of the four data bytes, and issues a single RAM write strobe with the averaged byte. It sits directly upstream of the RAM address counter and the RAM. Its `ram_ena` drives both the RAM write enable and the address counter's decrement. Both blocks run on `clk_2`.

---
 rtl/packet_pkg.sv | 24 ++
 rtl/packet_averager_if.sv | 29 ++
 rtl/packet_averager_byte_accumulator.sv | 40 ++++
 rtl/packet_averager.sv | 95 +++++++++
 tb/tb_packet_averager.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/packet_pkg.sv
// Shared types and constants for the packet averager and the RAM address counter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package packet_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        WRITE = 2'd2
    } pa_state_t;

    localparam logic [7:0] HDR_A  = 8'hA5;
    localparam logic [7:0] HDR_B  = 8'hC3;
    localparam int         N_DATA = 4;
    localparam int         SUM_W  = 10;

    // True when b matches either of the two accepted header values.
    function automatic logic is_hdr(input logic [7:0] b,
                                    input logic [7:0] hdr_a,
                                    input logic [7:0] hdr_b);
        return (b == hdr_a) || (b == hdr_b);
    endfunction

endpackage

// File: rtl/packet_averager_if.sv
// Byte-stream input and RAM write-strobe output bundle of the packet averager.
// Latency: n/a (wiring only).
// Backpressure: none; byte_valid is a one-cycle strobe and the averager always accepts it.
// Ports: byte_in/byte_valid (source -> averager), ram_ena/ram_data/busy (averager -> RAM side).
interface packet_averager_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       ram_ena;
    logic [7:0] ram_data;
    logic       busy;

    // Byte source / RAM side
    modport master (
        output byte_in,
        output byte_valid,
        input  ram_ena,
        input  ram_data,
        input  busy
    );

    // The averager itself
    modport slave (
        input  byte_in,
        input  byte_valid,
        output ram_ena,
        output ram_data,
        output busy
    );
endinterface

// File: rtl/packet_averager_byte_accumulator.sv
// Running 10-bit sum and 2-bit byte count for one packet's data bytes.
// Latency: sum/count update on the clock edge that samples i_add; o_last is decoded from the registered count.
// Backpressure: none; an add is accepted every cycle it is asserted.
// Ports: i_clk, i_rst_n (sync, active-low), i_clr (zero sum and count), i_add + i_dat (accumulate a byte),
//        o_sum (current sum), o_last (count shows N-1 bytes taken, so the next add completes the packet).
module byte_accumulator
    import packet_pkg::*;
#(
    parameter int N = N_DATA
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_add,
    input  logic [7:0]       i_dat,
    output logic [SUM_W-1:0] o_sum,
    output logic             o_last
);

    logic [SUM_W-1:0] r_sum;
    logic [1:0]       r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sum <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
            r_cnt <= '0;
        end else if (i_add) begin
            // Four bytes of at most 255 fit in 10 bits, so no saturation is needed.
            r_sum <= r_sum + SUM_W'(i_dat);
            r_cnt <= r_cnt + 2'd1;
        end
    end

    assign o_sum  = r_sum;
    assign o_last = (r_cnt == 2'(N - 1));

endmodule

// File: rtl/packet_averager.sv
// Frames header + 4 data bytes into a packet and issues one RAM write strobe carrying the truncated mean.
// Latency: ram_ena/ram_data are registered on the edge that samples the 4th data byte (high for exactly one cycle).
// Backpressure: none; every strobed byte is consumed or discarded, and a header in the WRITE cycle starts the next packet.
// Ports: clk_2, reset_n (sync, active-low); bus (slave modport): byte_in/byte_valid in, ram_ena/ram_data/busy out.
module packet_averager #(
    parameter logic [7:0] HDR_A  = packet_pkg::HDR_A,
    parameter logic [7:0] HDR_B  = packet_pkg::HDR_B,
    parameter int         N_DATA = packet_pkg::N_DATA
) (
    input  logic               clk_2,
    input  logic               reset_n,
    packet_averager_if.slave   bus
);
    import packet_pkg::*;

    pa_state_t        r_state;
    pa_state_t        w_state_nxt;
    logic             r_ram_ena;
    logic [7:0]       r_ram_data;
    logic             w_ram_ena_nxt;
    logic             w_clr;
    logic             w_add;
    logic             w_hdr;
    logic             w_last;
    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] w_sum_full;
    logic [7:0]       w_avg;

    byte_accumulator #(
        .N (N_DATA)
    ) u_acc (
        .i_clk   (clk_2),
        .i_rst_n (reset_n),
        .i_clr   (w_clr),
        .i_add   (w_add),
        .i_dat   (bus.byte_in),
        .o_sum   (w_sum),
        .o_last  (w_last)
    );

    assign w_hdr = bus.byte_valid && is_hdr(bus.byte_in, HDR_A, HDR_B);

    // The write is registered on the same edge that takes the 4th byte, so the
    // mean is formed from the sum including the byte being sampled now.
    assign w_sum_full = w_sum + SUM_W'(bus.byte_in);
    assign w_avg      = 8'(w_sum_full >> 2);

    always_comb begin
        w_state_nxt   = r_state;
        w_clr         = 1'b0;
        w_add         = 1'b0;
        w_ram_ena_nxt = 1'b0;
        case (r_state)
            // WRITE accepts a header exactly like IDLE so back-to-back packets are kept.
            IDLE, WRITE: begin
                if (w_hdr) begin
                    w_state_nxt = ACC;
                    w_clr       = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACC: begin
                if (bus.byte_valid) begin
                    w_add = 1'b1;
                    if (w_last) begin
                        w_state_nxt   = WRITE;
                        w_ram_ena_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_ram_ena  <= 1'b0;
            r_ram_data <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_ram_ena <= w_ram_ena_nxt;
            // ram_data holds between writes.
            if (w_ram_ena_nxt) begin
                r_ram_data <= w_avg;
            end
        end
    end

    assign bus.ram_ena  = r_ram_ena;
    assign bus.ram_data = r_ram_data;
    assign bus.busy     = (r_state != IDLE);

endmodule

// File: tb/tb_packet_averager.sv
// Self-checking bench for packet_averager: directed packets plus random byte stream with resets.
// Latency: expected write is due on the edge that samples the 4th data byte.
// Backpressure: none exercised (the design has none).
module tb_packet_averager;

    logic clk_2   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk_2 = ~clk_2;

    packet_averager_if u_if ();

    packet_averager u_dut (
        .clk_2   (clk_2),
        .reset_n (reset_n),
        .bus     (u_if.slave)
    );

    typedef struct {
        logic [7:0] dat;
        int         cyc;
    } exp_t;

    exp_t q_exp[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit mon_on = 1'b0;
    bit prev_ena = 1'b0;

    // Reference model: packet framing as plain lists of bytes.
    bit         m_in_pkt = 1'b0;
    logic [7:0] m_data[$];
    logic       exp_busy = 1'b0;
    logic [7:0] exp_data = 8'h00;

    always @(posedge clk_2) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write.
    always @(negedge clk_2) begin
        if (mon_on) begin
            if (u_if.ram_ena === 1'b1) begin
                if (prev_ena) chk("no_consecutive_ena", 32'(prev_ena), 32'd0);
                if (q_exp.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q_exp.pop_front();
                    chk("ram_data_on_write", 32'(u_if.ram_data), 32'(e.dat));
                    chk("write_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            prev_ena = (u_if.ram_ena === 1'b1);
        end
    end

    function automatic bit hdr(input logic [7:0] b);
        return (b == 8'hA5) || (b == 8'hC3);
    endfunction

    // One clock of stimulus: checks held outputs, drives inputs, advances the model.
    task automatic step(input bit v, input logic [7:0] b, input bit rst);
        bit wrote;
        @(negedge clk_2);
        chk("busy", 32'(u_if.busy), 32'(exp_busy));
        chk("ram_data_hold", 32'(u_if.ram_data), 32'(exp_data));
        u_if.byte_valid = v;
        u_if.byte_in    = b;
        reset_n         = ~rst;
        wrote = 1'b0;
        if (rst) begin
            m_in_pkt = 1'b0;
            m_data.delete();
            exp_data = 8'h00;
        end else if (v) begin
            if (!m_in_pkt) begin
                if (hdr(b)) begin
                    m_in_pkt = 1'b1;
                    m_data.delete();
                end
            end else begin
                m_data.push_back(b);
                if (m_data.size() == 4) begin
                    int s;
                    exp_t e;
                    s = 0;
                    foreach (m_data[i]) s += int'(m_data[i]);
                    e.dat = 8'(s / 4);
                    e.cyc = cyc + 1;
                    q_exp.push_back(e);
                    exp_data = e.dat;
                    m_in_pkt = 1'b0;
                    wrote    = 1'b1;
                end
            end
        end
        exp_busy = m_in_pkt || wrote;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic seq(input logic [7:0] bytes[$], input int gap);
        foreach (bytes[i]) begin
            step(1'b1, bytes[i], 1'b0);
            if (gap > 0) idle(gap);
        end
    endtask

    initial begin
        u_if.byte_valid = 1'b0;
        u_if.byte_in    = 8'h00;
        reset_n         = 1'b0;
        repeat (2) @(posedge clk_2);
        @(negedge clk_2);
        chk("reset_ram_ena", 32'(u_if.ram_ena), 32'd0);
        chk("reset_ram_data", 32'(u_if.ram_data), 32'd0);
        chk("reset_busy", 32'(u_if.busy), 32'd0);
        mon_on = 1'b1;
        reset_n = 1'b1;

        // Basic packet: mean of 10,20,30,40 is 25.
        seq('{8'hA5, 8'd10, 8'd20, 8'd30, 8'd40}, 0);
        idle(3);
        // Full-scale and truncation.
        seq('{8'hC3, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0);
        idle(2);
        seq('{8'hC3, 8'h01, 8'h01, 8'h01, 8'h00}, 0);
        idle(2);
        // Junk before header is discarded.
        seq('{8'h00, 8'h11, 8'h5A, 8'hA5, 8'h04, 8'h04, 8'h04, 8'h04}, 0);
        idle(2);
        // Back-to-back packets, header lands in the WRITE cycle.
        seq('{8'hA5, 8'h08, 8'h08, 8'h08, 8'h08, 8'hC3, 8'h10, 8'h10, 8'h10, 8'h10}, 0);
        idle(2);
        // Reset mid-packet drops it; following bytes have no header.
        seq('{8'hA5, 8'd10, 8'd20}, 0);
        step(1'b0, 8'h00, 1'b1);
        seq('{8'd30, 8'd40, 8'd50, 8'd60}, 0);
        idle(2);
        // Header values inside the data, with gaps between strobes.
        seq('{8'hA5, 8'hA5, 8'hC3, 8'h00, 8'h00}, 2);
        idle(3);

        // Random stream, header-heavy, occasional reset.
        for (int i = 0; i < 4000; i++) begin
            bit         v;
            bit         r;
            logic [7:0] b;
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 9))
                0, 1:    b = 8'hA5;
                2:       b = 8'hC3;
                default: b = 8'($urandom);
            endcase
            step(v, b, r);
        end
        idle(4);
        chk("scoreboard_drained", 32'(q_exp.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
